// File: rtl/ac97_sin_pkg.sv
// Shared constants and types for the AC-link serial input deserializer.
// Slot end indices are the frame bit index of each captured slot's LSB.
package ac97_sin_pkg;

   localparam int FRAME_LEN = 256;
   localparam int CNT_W     = 8;
   localparam int SLT0_W    = 16;
   localparam int SLT_W     = 20;

   localparam logic [CNT_W-1:0] SLT0_END = 8'd15;
   localparam logic [CNT_W-1:0] SLT1_END = 8'd35;
   localparam logic [CNT_W-1:0] SLT2_END = 8'd55;
   localparam logic [CNT_W-1:0] SLT3_END = 8'd75;
   localparam logic [CNT_W-1:0] SLT4_END = 8'd95;
   localparam logic [CNT_W-1:0] SLT6_END = 8'd135;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ac97_state_e;

endpackage

// File: rtl/ac97_sin.sv
// AC-link receive deserializer: locks to SYNC rising edges, shifts sdata_in MSB first
// and captures slots 0,1,2,3,4,6 with tag-qualified valid pulses and SYNC error flags.
module ac97_sin
   import ac97_sin_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              sync,
   input  logic              sdata_in,
   output logic [SLT0_W-1:0] slt0,
   output logic [SLT_W-1:0]  slt1,
   output logic [SLT_W-1:0]  slt2,
   output logic [SLT_W-1:0]  slt3,
   output logic [SLT_W-1:0]  slt4,
   output logic [SLT_W-1:0]  slt6,
   output logic              codec_ready,
   output logic [4:0]        in_valid,
   output logic              frame_done,
   output logic              sync_err,
   output ac97_state_e       dbg_state
);

   ac97_state_e       state, state_nxt;
   logic              sync_d;
   logic              rise;
   logic              wrap;
   logic              cap_en;
   logic              frame_done_nxt;
   logic              sync_err_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [SLT_W-2:0]  sh;
   logic [SLT_W-1:0]  word;

   // bit_cnt holds the frame index of the bit being sampled this cycle while in RUN;
   // a rise always re-anchors that bit to index 0.
   assign rise      = sync & ~sync_d;
   assign wrap      = (bit_cnt == '0);
   assign word      = {sh, sdata_in};
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (rise) state_nxt = ST_RUN;
         ST_RUN:  if (wrap && !rise) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Wrap without a rise is a missing SYNC; a rise anywhere else is an early SYNC.
   always_comb begin
      frame_done_nxt = 1'b0;
      sync_err_nxt   = 1'b0;
      cap_en         = 1'b0;
      if (state == ST_RUN) begin
         frame_done_nxt = wrap;
         sync_err_nxt   = wrap ^ rise;
         cap_en         = ~rise;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_d      <= 1'b1;
         sh          <= '0;
         bit_cnt     <= '0;
         slt0        <= '0;
         slt1        <= '0;
         slt2        <= '0;
         slt3        <= '0;
         slt4        <= '0;
         slt6        <= '0;
         codec_ready <= 1'b0;
         in_valid    <= '0;
         frame_done  <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         sync_d     <= sync;
         sh         <= word[SLT_W-2:0];
         frame_done <= frame_done_nxt;
         sync_err   <= sync_err_nxt;
         in_valid   <= '0;
         if (rise)                 bit_cnt <= CNT_W'(1);
         else if (state == ST_RUN) bit_cnt <= bit_cnt + CNT_W'(1);
         else                      bit_cnt <= '0;
         if (cap_en) begin
            case (bit_cnt)
               SLT0_END: begin
                  slt0        <= word[SLT0_W-1:0];
                  codec_ready <= word[SLT0_W-1];
               end
               SLT1_END: begin slt1 <= word; in_valid[0] <= slt0[14]; end
               SLT2_END: begin slt2 <= word; in_valid[1] <= slt0[13]; end
               SLT3_END: begin slt3 <= word; in_valid[2] <= slt0[12]; end
               SLT4_END: begin slt4 <= word; in_valid[3] <= slt0[11]; end
               SLT6_END: begin slt6 <= word; in_valid[4] <= slt0[9];  end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ac97_sin.sv
// Self-checking bench for ac97_sin: random frames against a frame-level model that
// collects bits per frame and extracts slots by position.
module tb_ac97_sin;
   import ac97_sin_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sync = 1'b0;
   logic        sdata_in = 1'b0;
   logic [15:0] slt0;
   logic [19:0] slt1, slt2, slt3, slt4, slt6;
   logic        codec_ready;
   logic [4:0]  in_valid;
   logic        frame_done;
   logic        sync_err;
   ac97_state_e dbg_state;

   int total = 0;
   int bad   = 0;

   ac97_sin dut (
      .clk(clk), .rst(rst), .sync(sync), .sdata_in(sdata_in),
      .slt0(slt0), .slt1(slt1), .slt2(slt2), .slt3(slt3), .slt4(slt4), .slt6(slt6),
      .codec_ready(codec_ready), .in_valid(in_valid), .frame_done(frame_done),
      .sync_err(sync_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic        m_bits [256];
   int          m_n;
   bit          m_run;
   bit          m_sync_d;
   logic [15:0] e_slt0;
   logic [19:0] e_slt1, e_slt2, e_slt3, e_slt4, e_slt6;
   logic        e_cr, e_fd, e_se;
   logic [4:0]  e_iv;
   logic        f_bits [256];

   function automatic logic [19:0] extract(input int start, input int w);
      logic [19:0] v = '0;
      for (int i = 0; i < w; i++) v = {v[18:0], m_bits[start+i]};
      return v;
   endfunction

   task automatic model_reset();
      m_n = 0; m_run = 0; m_sync_d = 1;
      e_slt0 = '0; e_slt1 = '0; e_slt2 = '0; e_slt3 = '0; e_slt4 = '0; e_slt6 = '0;
      e_cr = 0; e_fd = 0; e_se = 0; e_iv = '0;
   endtask

   task automatic model_take(input logic d);
      logic [19:0] v;
      m_bits[m_n] = d;
      m_n++;
      if (m_n == 16) begin
         e_slt0 = 16'(extract(0, 16));
         e_cr   = e_slt0[15];
      end
      for (int n = 1; n <= 6; n++) begin
         if (n != 5 && m_n == 16 + 20*n) begin
            v = extract(20*n - 4, 20);
            case (n)
               1: e_slt1 = v;
               2: e_slt2 = v;
               3: e_slt3 = v;
               4: e_slt4 = v;
               default: e_slt6 = v;
            endcase
            e_iv[(n == 6) ? 4 : n-1] = e_slt0[15-n];
         end
      end
   endtask

   task automatic model_step(input logic s, input logic d);
      bit r;
      r = s && !m_sync_d;
      m_sync_d = s;
      e_iv = '0; e_fd = 0; e_se = 0;
      if (!m_run) begin
         if (r) begin m_run = 1; m_n = 0; model_take(d); end
      end else if (m_n == 256) begin
         e_fd = 1;
         if (r) begin m_n = 0; model_take(d); end
         else begin e_se = 1; m_run = 0; end
      end else if (r) begin
         e_se = 1; m_n = 0; model_take(d);
      end else begin
         model_take(d);
      end
   endtask

   function automatic logic [123:0] dut_vec();
      return {slt0, slt1, slt2, slt3, slt4, slt6, codec_ready, in_valid, frame_done, sync_err};
   endfunction

   function automatic logic [123:0] exp_vec();
      return {e_slt0, e_slt1, e_slt2, e_slt3, e_slt4, e_slt6, e_cr, e_iv, e_fd, e_se};
   endfunction

   // ---------------- drivers ----------------
   task automatic build_frame(input logic [15:0] s0, input logic [19:0] s1, input logic [19:0] s2,
                              input logic [19:0] s3, input logic [19:0] s4, input logic [19:0] s6);
      logic [19:0] v;
      for (int i = 0; i < 16; i++) f_bits[i] = s0[15-i];
      for (int n = 1; n <= 12; n++) begin
         case (n)
            1: v = s1;
            2: v = s2;
            3: v = s3;
            4: v = s4;
            6: v = s6;
            default: v = 20'($urandom);
         endcase
         for (int b = 0; b < 20; b++) f_bits[20*n - 4 + b] = v[19-b];
      end
   endtask

   task automatic step(input logic s, input logic d);
      sync = s;
      sdata_in = d;
      @(posedge clk);
      model_step(s, d);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; sync = 1'b0; sdata_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst = 1'b0;
      model_reset();
      #2;
      total++;
      if (dut_vec() !== '0 || dbg_state !== ST_IDLE) begin
         bad++; $display("FAIL reset_async: got=%h st=%0d exp=0 st=0", dut_vec(), dbg_state);
      end
      @(posedge clk); #1 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, rbit());
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_sync_high i=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_tagged_frame();
      logic [4:0] iv_or = '0;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, rbit());
      build_frame(16'hF800, 20'h12345, 20'hABCDE, 20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i < 256; i++) begin
         step(i < 16, f_bits[i]);
         iv_or |= in_valid;
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL tagged_model bit=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         if (i == 15) begin
            total++;
            if (slt0 !== 16'hF800 || codec_ready !== 1'b1) begin
               bad++; $display("FAIL tagged_slt0: got=%h/%b exp=f800/1", slt0, codec_ready);
            end
         end
         if (i == 35) begin
            total++;
            if (slt1 !== 20'h12345 || in_valid !== 5'b00001) begin
               bad++; $display("FAIL tagged_slt1: got=%h/%b exp=12345/00001", slt1, in_valid);
            end
         end
         if (i == 55) begin
            total++;
            if (slt2 !== 20'hABCDE || in_valid !== 5'b00010) begin
               bad++; $display("FAIL tagged_slt2: got=%h/%b exp=abcde/00010", slt2, in_valid);
            end
         end
      end
      total++;
      if (iv_or !== 5'b01111) begin
         bad++; $display("FAIL tagged_valid_set: got=%b exp=01111", iv_or);
      end
      step(1'b1, rbit());
      total++;
      if (frame_done !== 1'b1 || sync_err !== 1'b0) begin
         bad++; $display("FAIL tagged_frame_done: got=%b/%b exp=1/0", frame_done, sync_err);
      end
   endtask

   task automatic test_untagged_slot();
      logic [4:0] iv_or = '0;
      do_reset();
      step(1'b0, rbit());
      build_frame(16'h8000, 20'($urandom), 20'($urandom), 20'hABCDE, 20'($urandom), 20'($urandom));
      for (int i = 0; i < 256; i++) begin
         step(i < 16, f_bits[i]);
         iv_or |= in_valid;
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL untagged_model bit=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         if (i == 75) begin
            total++;
            if (slt3 !== 20'hABCDE || in_valid !== 5'b00000 || codec_ready !== 1'b1) begin
               bad++; $display("FAIL untagged_slt3: got=%h/%b/%b exp=abcde/00000/1", slt3, in_valid, codec_ready);
            end
         end
      end
      total++;
      if (iv_or !== 5'b00000) begin
         bad++; $display("FAIL untagged_no_valid: got=%b exp=00000", iv_or);
      end
   endtask

   task automatic test_back_to_back();
      int fd_at[$];
      int se_cnt = 0;
      int k = 0;
      do_reset();
      step(1'b0, rbit());
      for (int f = 0; f < 4; f++) begin
         build_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
         for (int i = 0; i < ((f == 3) ? 40 : 256); i++) begin
            step(i < 16, f_bits[i]);
            if (frame_done === 1'b1) fd_at.push_back(k);
            if (sync_err === 1'b1) se_cnt++;
            k++;
            total++;
            if (dut_vec() !== exp_vec()) begin
               bad++; $display("FAIL b2b_model f=%0d bit=%0d: got=%h exp=%h", f, i, dut_vec(), exp_vec());
            end
         end
      end
      total++;
      if (fd_at.size() != 3 || se_cnt != 0) begin
         bad++; $display("FAIL b2b_counts: got fd=%0d se=%0d exp fd=3 se=0", fd_at.size(), se_cnt);
      end else begin
         for (int j = 0; j < 3; j++) begin
            total++;
            if (fd_at[j] != 256*(j+1)) begin
               bad++; $display("FAIL b2b_spacing j=%0d: got=%0d exp=%0d", j, fd_at[j], 256*(j+1));
            end
         end
      end
   endtask

   task automatic test_early_sync();
      int fd_cnt = 0;
      int se_cnt = 0;
      logic [15:0] b_s0;
      logic [19:0] b_s2;
      do_reset();
      step(1'b0, rbit());
      build_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i < 100; i++) begin
         step(i < 16, f_bits[i]);
         fd_cnt += int'(frame_done); se_cnt += int'(sync_err);
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL early_a bit=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
      end
      b_s0 = 16'($urandom);
      b_s2 = 20'($urandom);
      build_frame(b_s0, 20'($urandom), b_s2, 20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i < 256; i++) begin
         step(i < 16, f_bits[i]);
         fd_cnt += int'(frame_done); se_cnt += int'(sync_err);
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL early_b bit=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         if (i == 0) begin
            total++;
            if (sync_err !== 1'b1) begin
               bad++; $display("FAIL early_err_pulse: got=%b exp=1", sync_err);
            end
         end
         if (i == 15) begin
            total++;
            if (slt0 !== b_s0) begin
               bad++; $display("FAIL early_new_slt0: got=%h exp=%h", slt0, b_s0);
            end
         end
      end
      total++;
      if (fd_cnt != 0 || se_cnt != 1) begin
         bad++; $display("FAIL early_counts: got fd=%0d se=%0d exp fd=0 se=1", fd_cnt, se_cnt);
      end
      // Next frame aborted exactly at slot 2's last bit: slot 2 must keep frame B's value.
      build_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i < 55; i++) begin
         step(i < 16, f_bits[i]);
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL early_c bit=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
      end
      step(1'b1, rbit());
      total++;
      if (slt2 !== b_s2 || sync_err !== 1'b1 || in_valid !== 5'b00000) begin
         bad++; $display("FAIL early_slot_drop: got=%h/%b/%b exp=%h/1/00000", slt2, sync_err, in_valid, b_s2);
      end
   endtask

   task automatic test_missing_sync();
      logic [15:0] n_s0;
      do_reset();
      step(1'b0, rbit());
      build_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i < 256; i++) begin
         step(i < 16, f_bits[i]);
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL missing_model bit=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, rbit());
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL missing_idle i=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         if (i == 0) begin
            total++;
            if (frame_done !== 1'b1 || sync_err !== 1'b1 || dbg_state !== ST_IDLE) begin
               bad++; $display("FAIL missing_pulses: got fd=%b se=%b st=%0d exp 1/1/0", frame_done, sync_err, dbg_state);
            end
         end
      end
      n_s0 = 16'($urandom);
      build_frame(n_s0, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i < 16; i++) step(1'b1, f_bits[i]);
      total++;
      if (slt0 !== n_s0 || dbg_state !== ST_RUN) begin
         bad++; $display("FAIL missing_resume: got=%h st=%0d exp=%h st=1", slt0, dbg_state, n_s0);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] n_s0;
      do_reset();
      step(1'b0, rbit());
      build_frame(16'($urandom) | 16'h0001, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i <= 50; i++) step(i < 16, f_bits[i]);
      total++;
      if (dut_vec() !== exp_vec()) begin
         bad++; $display("FAIL midrst_pre: got=%h exp=%h", dut_vec(), exp_vec());
      end
      #2 rst = 1'b0;
      #1;
      model_reset();
      total++;
      if (dut_vec() !== '0 || dbg_state !== ST_IDLE) begin
         bad++; $display("FAIL midrst_async: got=%h st=%0d exp=0 st=0", dut_vec(), dbg_state);
      end
      sync = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b1, rbit());
      total++;
      if (dut_vec() !== '0 || dbg_state !== ST_IDLE) begin
         bad++; $display("FAIL midrst_hold_high: got=%h st=%0d exp=0 st=0", dut_vec(), dbg_state);
      end
      for (int i = 0; i < 3; i++) step(1'b0, rbit());
      n_s0 = 16'($urandom);
      build_frame(n_s0, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i < 40; i++) begin
         step(i < 16, f_bits[i]);
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL midrst_resume bit=%0d: got=%h exp=%h", i, dut_vec(), exp_vec());
         end
      end
      total++;
      if (slt0 !== n_s0) begin
         bad++; $display("FAIL midrst_slt0: got=%h exp=%h", slt0, n_s0);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_tagged_frame();
      test_untagged_slot();
      test_back_to_back();
      test_early_sync();
      test_missing_sync();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
